// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator.
// One shared period counter (edge- or center-aligned) feeds NUM_CH compare
// channels. Duty updates are shadowed and applied at period boundaries; any
// output edge opens a blanking window on the overcurrent comparator input.
module pwm_multi_gen #(
    parameter int WIDTH     = 11,
    parameter int NUM_CH    = 3,
    parameter int BLANK_CNT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic                    duty_wr,
    output logic                    duty_upd,
    output logic [NUM_CH-1:0]       PWM_sig,
    output logic                    PWM_synch,
    output logic                    OVR_I_blank_n
);

    localparam logic [WIDTH-1:0] MAX        = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [15:0]      BLANK_LOAD = 16'(BLANK_CNT);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [WIDTH-1:0]        cnt_q, cnt_d;
    dir_e                    dir_q, dir_d;
    logic                    mode_act_q, mode_act_d;
    logic [NUM_CH*WIDTH-1:0] duty_act_q, duty_act_d;
    logic [NUM_CH*WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic                    pend_q, pend_d;
    logic                    upd_q, upd_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic                    synch_q, synch_d;
    logic                    blank_n_q, blank_n_d;
    logic [15:0]             blank_cnt_q, blank_cnt_d;

    logic last_cnt;
    logic boundary;
    logic load;
    logic toggle;

    // Period counter: detect the last count of the active mode, then advance
    // or restart. A disabled generator behaves as if sitting on a boundary.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_act_d = mode_act_q;

        last_cnt = mode_act_q ? ((cnt_q == ONE) && (dir_q == DIR_DOWN))
                              : (cnt_q == MAX);
        boundary = en && last_cnt;
        load     = !en || boundary;

        if (load) begin
            cnt_d      = '0;
            dir_d      = DIR_UP;
            mode_act_d = mode;
        end else if (mode_act_q && (dir_q == DIR_DOWN)) begin
            cnt_d = cnt_q - ONE;
        end else if (mode_act_q && (cnt_q == MAX)) begin
            cnt_d = cnt_q - ONE;
            dir_d = DIR_DOWN;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Duty shadowing: writes park in the pending set and move to the active
    // set on a load edge; a write on the load edge itself goes straight through.
    always_comb begin
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        pend_d      = pend_q;
        upd_d       = 1'b0;

        if (load) begin
            if (duty_wr) begin
                duty_act_d  = duty_in;
                duty_pend_d = duty_in;
                upd_d       = 1'b1;
            end else begin
                duty_act_d = duty_pend_q;
                upd_d      = pend_q;
            end
            pend_d = 1'b0;
        end else if (duty_wr) begin
            duty_pend_d = duty_in;
            pend_d      = 1'b1;
        end
    end

    // Compare stage: each channel is high while the counter is below its duty.
    always_comb begin
        pwm_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_d[k] = en && (cnt_q < duty_act_q[k*WIDTH +: WIDTH]);
        end
        synch_d = boundary;
    end

    // Blanking window: any output edge reloads the window; the comparator is
    // unblanked once the window has fully elapsed with no further edge.
    always_comb begin
        blank_cnt_d = blank_cnt_q;
        blank_n_d   = blank_n_q;
        toggle      = |(pwm_d ^ pwm_q);

        if (toggle) begin
            blank_cnt_d = BLANK_LOAD;
            blank_n_d   = 1'b0;
        end else if (blank_cnt_q != 16'd0) begin
            blank_cnt_d = blank_cnt_q - 16'd1;
            blank_n_d   = (blank_cnt_q == 16'd1);
        end else begin
            blank_n_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            mode_act_q  <= 1'b0;
            duty_act_q  <= '0;
            duty_pend_q <= '0;
            pend_q      <= 1'b0;
            upd_q       <= 1'b0;
            pwm_q       <= '0;
            synch_q     <= 1'b0;
            blank_n_q   <= 1'b0;
            blank_cnt_q <= BLANK_LOAD;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            mode_act_q  <= mode_act_d;
            duty_act_q  <= duty_act_d;
            duty_pend_q <= duty_pend_d;
            pend_q      <= pend_d;
            upd_q       <= upd_d;
            pwm_q       <= pwm_d;
            synch_q     <= synch_d;
            blank_n_q   <= blank_n_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign duty_upd      = upd_q;
    assign PWM_sig       = pwm_q;
    assign PWM_synch     = synch_q;
    assign OVR_I_blank_n = blank_n_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: the driver steps a period-position
// reference model each cycle and queues the expected outputs; an independent
// monitor pops and compares after every clock edge.
module tb_pwm_multi_gen;

    localparam int WIDTH     = 11;
    localparam int NUM_CH    = 3;
    localparam int BLANK_CNT = 255;
    localparam int MAXV      = (1 << WIDTH) - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic                    mode = 1'b0;
    logic [NUM_CH*WIDTH-1:0] duty_in = '0;
    logic                    duty_wr = 1'b0;
    logic                    duty_upd;
    logic [NUM_CH-1:0]       PWM_sig;
    logic                    PWM_synch;
    logic                    OVR_I_blank_n;

    pwm_multi_gen #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .BLANK_CNT(BLANK_CNT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .duty_upd     (duty_upd),
        .PWM_sig      (PWM_sig),
        .PWM_synch    (PWM_synch),
        .OVR_I_blank_n(OVR_I_blank_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] pwm;
        logic              synch;
        logic              upd;
        logic              blank_n;
    } out_t;

    out_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Stimulus values, applied to the DUT on the falling edge.
    logic             s_rst_n = 1'b0;
    logic             s_en    = 1'b0;
    logic             s_mode  = 1'b0;
    logic             s_wr    = 1'b0;
    logic [WIDTH-1:0] s_duty [NUM_CH];

    // Reference model: position p within the current period.
    int               m_p;
    int               m_mode;
    int               m_act  [NUM_CH];
    int               m_pend [NUM_CH];
    int               m_pflag;
    int               m_since;
    logic [NUM_CH-1:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic int m_len();
        return (m_mode != 0) ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int m_cnt();
        return (m_p <= MAXV) ? m_p : 2 * MAXV - m_p;
    endfunction

    // Advance the model by one clock edge with the current stimulus.
    task automatic model_step(output out_t e);
        logic [NUM_CH-1:0] pwm;
        int  c;
        logic bnd;
        logic upd;
        if (!s_rst_n) begin
            m_p = 0; m_mode = 0; m_pflag = 0; m_since = 0; m_prev = '0;
            for (int k = 0; k < NUM_CH; k++) begin m_act[k] = 0; m_pend[k] = 0; end
            e = '0;
            return;
        end
        c = m_cnt();
        for (int k = 0; k < NUM_CH; k++) pwm[k] = s_en && (c < m_act[k]);
        bnd = s_en && (m_p == m_len() - 1);
        upd = 1'b0;
        if (!s_en || bnd) begin
            if (s_wr) begin
                for (int k = 0; k < NUM_CH; k++) begin m_act[k] = s_duty[k]; m_pend[k] = s_duty[k]; end
                upd = 1'b1;
            end else begin
                upd = (m_pflag != 0);
                for (int k = 0; k < NUM_CH; k++) m_act[k] = m_pend[k];
            end
            m_pflag = 0;
            m_mode  = s_mode;
            m_p     = 0;
        end else begin
            if (s_wr) begin
                for (int k = 0; k < NUM_CH; k++) m_pend[k] = s_duty[k];
                m_pflag = 1;
            end
            m_p = m_p + 1;
        end
        if (pwm != m_prev) m_since = 0;
        else if (m_since < BLANK_CNT) m_since++;
        m_prev    = pwm;
        e.pwm     = pwm;
        e.synch   = bnd;
        e.upd     = upd;
        e.blank_n = (m_since >= BLANK_CNT);
    endtask

    task automatic step();
        out_t e;
        @(negedge clk);
        rst_n   = s_rst_n;
        en      = s_en;
        mode    = s_mode;
        duty_wr = s_wr;
        for (int k = 0; k < NUM_CH; k++) duty_in[k*WIDTH +: WIDTH] = s_duty[k];
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the next edge will see the given count (bounded).
    task automatic run_to_cnt(input int target);
        int i;
        for (i = 0; i < 10000 && m_cnt() != target; i++) step();
        if (m_cnt() != target) check("run_to_cnt_timeout", 32'(m_cnt()), 32'(target));
    endtask

    task automatic write_duties(input int d0, input int d1, input int d2);
        s_duty[0] = d0[WIDTH-1:0];
        s_duty[1] = d1[WIDTH-1:0];
        s_duty[2] = d2[WIDTH-1:0];
        s_wr = 1'b1;
        step();
        s_wr = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_duty();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return '0;
        if (r == 1) return WIDTH'(MAXV);
        return WIDTH'($urandom_range(0, MAXV));
    endfunction

    // Monitor: compare the DUT against the next queued expectation.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{pwm,synch,upd,blank_n}",
                      32'({PWM_sig, PWM_synch, duty_upd, OVR_I_blank_n}), 32'(e));
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        for (int k = 0; k < NUM_CH; k++) s_duty[k] = '0;

        // Reset, then edge mode with an aborted period.
        run(2);
        s_rst_n = 1'b1;
        write_duties(12'h400, 12'h7FF, 0);
        s_en = 1'b1;
        run_to_cnt(12'h123);
        s_rst_n = 1'b0;
        run(3);
        s_rst_n = 1'b1;
        s_en = 1'b0;
        write_duties(12'h400, 12'h7FF, 0);
        s_en = 1'b1;
        run(3 * 2048);

        // Shadowed write mid-period, then a write on the boundary edge.
        run_to_cnt(12'h200);
        write_duties(12'h100, 12'h7FF, 0);
        run(2 * 2048);
        run_to_cnt(MAXV);
        write_duties(12'h300, 12'h7FF, 0);
        run(2048);

        // Center-aligned mode.
        s_mode = 1'b1;
        write_duties(12'h200, 12'h7FF, 0);
        run(3 * 4094);

        // Back to edge mode, two channels falling 100 cycles apart.
        s_mode = 1'b0;
        write_duties(12'h400, 12'h464, 12'h400);
        run(4094 + 2 * 2048);

        // Enable drop while high, duty change while disabled.
        run_to_cnt(12'h300);
        s_en = 1'b0;
        run(5);
        write_duties(12'h050, 12'h7FF, 0);
        s_en = 1'b1;
        run(2048);

        // Randomized traffic.
        for (int i = 0; i < 15000; i++) begin
            s_wr = ($urandom_range(0, 49) == 0);
            if (s_wr) for (int k = 0; k < NUM_CH; k++) s_duty[k] = rand_duty();
            if ($urandom_range(0, 2999) == 0) s_mode = ~s_mode;
            if ($urandom_range(0, 2999) == 0) s_en = 1'b0;
            else if ($urandom_range(0, 7) == 0) s_en = 1'b1;
            s_rst_n = ($urandom_range(0, 9999) != 0);
            step();
        end
        s_wr = 1'b0;
        s_rst_n = 1'b1;
        run(4);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
